prog_sync_counter: RTL and testbench
====================================

// Module: prog_sync_counter
// PURPOSE
//  Parametrised synchronous counter: next generation of the 74163-style counter.
//  - Width and modulus are configurable.
//  - An internal prescaler sets the count rate.
//  - Synchronous clear and load; cascadable through Ep/Et and RCO.
//  - Acts as the timebase/digit stage for display and timer blocks on the 100 MHz clk.
// PARAMETERS
//  WIDTH     4     counter width in bits (1..16)
//  MODULUS   16    count states 0..MODULUS-1; must be 2..2**WIDTH
//  PRESCALE  1000  clk cycles per count step while enabled; 1 = step every cycle
// PORTS
//  clk       in   1      system clock, rising edge
//  rst       in   1      asynchronous, active-high reset
//  clear_n   in   1      synchronous clear, active-low
//  load_n    in   1      synchronous load of i_preset, active-low
//  ep        in   1      count enable P
//  et        in   1      count enable T; also gates o_rco
//  i_preset  in   WIDTH  load value
//  o_q       out  WIDTH  count value (registered)
//  o_tick    out  1      step strobe: high in the cycle before o_q advances
//  o_rco     out  1      ripple carry: et & (o_q == terminal)
//  up_dn     in   1      1 = up, 0 = down (only with SYNC_CNT_UPDOWN_EN)
// BEHAVIOUR
//  - rst asserted: o_q=0, prescaler=0 immediately (async); o_tick=0; o_rco=0 unless et=1 and terminal==0.
//  - Priority at each posedge: clear_n=0 > load_n=0 > count > hold.
//  - clear_n=0: o_q<=0, prescaler<=0.
//  - load_n=0: o_q<=i_preset, prescaler<=0.
//    - Loaded value is used unmodified, even if >= MODULUS.
//  - en = ep & et. Prescaler pre counts 0..PRESCALE-1 only while en=1; holds when en=0.
//  - o_tick = en & (pre==PRESCALE-1), combinational.
//    - On the edge where o_tick=1: pre<=0 and o_q steps.
//    - Latency: first step PRESCALE cycles after en rises with pre=0.
//  - Up step: o_q==MODULUS-1 or o_q>=MODULUS -> 0; else o_q+1.
//  - Down step: o_q==0 -> MODULUS-1; o_q>=MODULUS -> MODULUS-1; else o_q-1.
//  - Terminal count = MODULUS-1 when counting up, 0 when counting down.
//  - o_rco is combinational and does not depend on ep; this allows cascading:
//    next stage et <= o_rco, next stage ep <= o_tick.
//  - en dropping mid-prescale freezes pre; counting resumes from the frozen value.
//  - clear_n/load_n asserted in a cycle with o_tick=1: clear/load wins; no step occurs.
//  - rst mid-count: immediate return to the reset state; no step in progress survives.
//  - All arithmetic is unsigned. Prescaler width = clog2(PRESCALE), minimum 1 bit.
// CONFIGURATION
//  - SYNC_CNT_UPDOWN_EN defined: up_dn port exists; direction is sampled each step.
//    - Changing up_dn also changes the terminal used by o_rco in the same cycle.
//  - SYNC_CNT_UPDOWN_EN undefined: no up_dn port; up-count only; terminal = MODULUS-1.
// STRUCTURE
//  - Package sync_cnt_pkg holds:
//    - function clog2;
//    - localparam-derived widths (PRE_W);
//    - typedef of the count direction enum (CNT_UP, CNT_DN).
//  - Sub-module tick_prescaler (clk, rst, clr, en -> tick): owns pre and generates o_tick.
//    - clr = ~clear_n | ~load_n.
//  - Top level holds the o_q register, next-state/wrap logic and o_rco.
// TESTING  (WIDTH=4, MODULUS=10, PRESCALE=3 unless stated)
//  1. Reset: rst pulse mid-cycle -> o_q=0 immediately; ep=et=1 -> o_q 0->1 after 3 clks, 9->0 wrap.
//  2. Enable/RCO: et=1, ep=0 at o_q=9 -> o_rco=1, o_q holds; et=0 -> o_rco=0; pre frozen, resumes.
//  3. Load/clear: load_n=0 with i_preset=12 -> o_q=12, next step -> 0;
//     clear_n=0 & load_n=0 together -> o_q=0.
//  4. Collision: load_n=0 in the o_tick=1 cycle, i_preset=5 -> o_q=5, not 6; step 3 cycles later.
//  5. Cascade: two instances, PRESCALE=1 on the upper stage -> 00..99 sequence;
//     upper steps only when lower o_q=9.
//  6. SYNC_CNT_UPDOWN_EN: up_dn=0 from 0 -> 9; o_rco=1 at o_q=0; PRESCALE=1 steps every clk.

Source files
------------

// File: rtl/sync_cnt_pkg.sv
// Shared types and width helpers for prog_sync_counter and its prescaler.
package sync_cnt_pkg;

  typedef enum logic {
    CNT_DN = 1'b0,
    CNT_UP = 1'b1
  } cnt_dir_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 32'd0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) begin
        r = unsigned'(i) + 32'd1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // A prescaler of 1 still needs one register bit to exist.
  function automatic int unsigned pre_width(input int unsigned prescale);
    int unsigned w;
    w = clog2(prescale);
    return (w < 32'd1) ? 32'd1 : w;
  endfunction

  localparam int unsigned DEFAULT_PRESCALE = 32'd1000;
  localparam int unsigned PRE_W            = pre_width(DEFAULT_PRESCALE);

endpackage

// File: rtl/prog_sync_counter_tick_prescaler.sv
// tick_prescaler: divides clk while en is high and strobes tick on the last
// prescale cycle; the count freezes while en is low.
module tick_prescaler
  import sync_cnt_pkg::*;
#(
  parameter int unsigned PRESCALE = 32'd1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned           PRE_BITS = pre_width(PRESCALE);
  localparam logic [PRE_BITS-1:0]   PRE_LAST = PRE_BITS'(PRESCALE - 32'd1);

  logic [PRE_BITS-1:0] pre_r;
  logic [PRE_BITS-1:0] pre_nxt_s;
  logic                tick_s;

  // Tick decode and prescaler next value; clear/load restart the period.
  always_comb begin
    tick_s    = en & (pre_r == PRE_LAST);
    pre_nxt_s = pre_r;
    if (clr) begin
      pre_nxt_s = {PRE_BITS{1'b0}};
    end else if (tick_s) begin
      pre_nxt_s = {PRE_BITS{1'b0}};
    end else if (en) begin
      pre_nxt_s = pre_r + {{(PRE_BITS-1){1'b0}}, 1'b1};
    end else begin
      pre_nxt_s = pre_r;
    end
  end

  // Prescaler state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_r <= {PRE_BITS{1'b0}};
    end else begin
      pre_r <= pre_nxt_s;
    end
  end

  assign tick = tick_s;

endmodule

// File: rtl/prog_sync_counter.sv
// prog_sync_counter: parametrised 74163-style cascadable counter with prescaler.
// Define SYNC_CNT_UPDOWN_EN to add the up_dn port and down counting.
module prog_sync_counter
  import sync_cnt_pkg::*;
#(
  parameter int unsigned WIDTH    = 32'd4,
  parameter int unsigned MODULUS  = 32'd16,
  parameter int unsigned PRESCALE = 32'd1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_n,
  input  logic             load_n,
  input  logic             ep,
  input  logic             et,
  input  logic [WIDTH-1:0] i_preset,
`ifdef SYNC_CNT_UPDOWN_EN
  input  logic             up_dn,
`endif
  output logic [WIDTH-1:0] o_q,
  output logic             o_tick,
  output logic             o_rco
);

  localparam int unsigned        WP1     = WIDTH + 32'd1;
  localparam logic [WIDTH-1:0]   TERM_UP = WIDTH'(MODULUS - 32'd1);
  localparam logic [WIDTH:0]     MOD_EXT = WP1'(MODULUS);

  logic             en_s;
  logic             clr_s;
  logic             step_s;
  logic             ge_mod_s;
  cnt_dir_e         dir_s;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_nxt_s;
  logic [WIDTH-1:0] step_val_s;
  logic [WIDTH-1:0] term_s;

  assign en_s  = ep & et;
  assign clr_s = ~clear_n | ~load_n;

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_pre (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr_s),
    .en   (en_s),
    .tick (step_s)
  );

  // Count direction source.
  always_comb begin
`ifdef SYNC_CNT_UPDOWN_EN
    if (up_dn) begin
      dir_s = CNT_UP;
    end else begin
      dir_s = CNT_DN;
    end
`else
    dir_s = CNT_UP;
`endif
  end

  // Step value with wrap; out-of-range loaded values re-enter at the wrap point.
  always_comb begin
    ge_mod_s   = ({1'b0, q_r} >= MOD_EXT);
    step_val_s = q_r;
    term_s     = TERM_UP;
    case (dir_s)
      CNT_UP: begin
        term_s = TERM_UP;
        if ((q_r == TERM_UP) || ge_mod_s) begin
          step_val_s = {WIDTH{1'b0}};
        end else begin
          step_val_s = q_r + {{(WIDTH-1){1'b0}}, 1'b1};
        end
      end
      CNT_DN: begin
        term_s = {WIDTH{1'b0}};
        if ((q_r == {WIDTH{1'b0}}) || ge_mod_s) begin
          step_val_s = TERM_UP;
        end else begin
          step_val_s = q_r - {{(WIDTH-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        term_s     = TERM_UP;
        step_val_s = {WIDTH{1'b0}};
      end
    endcase
  end

  // Next count: clear beats load beats step beats hold.
  always_comb begin
    q_nxt_s = q_r;
    if (!clear_n) begin
      q_nxt_s = {WIDTH{1'b0}};
    end else if (!load_n) begin
      q_nxt_s = i_preset;
    end else if (step_s) begin
      q_nxt_s = step_val_s;
    end else begin
      q_nxt_s = q_r;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r <= {WIDTH{1'b0}};
    end else begin
      q_r <= q_nxt_s;
    end
  end

  assign o_q    = q_r;
  assign o_tick = step_s;
  assign o_rco  = et & (q_r == term_s);

endmodule

// File: tb/tb_prog_sync_counter.sv
// Self-checking bench for prog_sync_counter (WIDTH=4, MODULUS=10, PRESCALE=3),
// a two-digit cascade and a PRESCALE=1 instance; honours SYNC_CNT_UPDOWN_EN.
module tb_prog_sync_counter;

  localparam int W = 4;
  localparam int M = 10;
  localparam int P = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // main instance
  logic         rst, clear_n, load_n, ep, et;
  logic [W-1:0] preset;
  logic [W-1:0] q;
  logic         tick, rco;
  // cascade
  logic         c_clear_n, c_en;
  logic [W-1:0] lo_q, hi_q;
  logic         lo_tick, lo_rco, hi_tick, hi_rco;
  // single-cycle prescale instance
  logic         f_clear_n, f_en, f_up_dn;
  logic [W-1:0] f_q;
  logic         f_tick, f_rco;

  int m_q, m_pre;

  prog_sync_counter #(.WIDTH(W), .MODULUS(M), .PRESCALE(P)) dut (
    .clk(clk), .rst(rst), .clear_n(clear_n), .load_n(load_n), .ep(ep), .et(et),
    .i_preset(preset),
`ifdef SYNC_CNT_UPDOWN_EN
    .up_dn(1'b1),
`endif
    .o_q(q), .o_tick(tick), .o_rco(rco));

  prog_sync_counter #(.WIDTH(W), .MODULUS(M), .PRESCALE(P)) u_lo (
    .clk(clk), .rst(rst), .clear_n(c_clear_n), .load_n(1'b1), .ep(c_en), .et(c_en),
    .i_preset(4'd0),
`ifdef SYNC_CNT_UPDOWN_EN
    .up_dn(1'b1),
`endif
    .o_q(lo_q), .o_tick(lo_tick), .o_rco(lo_rco));

  prog_sync_counter #(.WIDTH(W), .MODULUS(M), .PRESCALE(1)) u_hi (
    .clk(clk), .rst(rst), .clear_n(c_clear_n), .load_n(1'b1), .ep(lo_tick), .et(lo_rco),
    .i_preset(4'd0),
`ifdef SYNC_CNT_UPDOWN_EN
    .up_dn(1'b1),
`endif
    .o_q(hi_q), .o_tick(hi_tick), .o_rco(hi_rco));

  prog_sync_counter #(.WIDTH(W), .MODULUS(M), .PRESCALE(1)) u_fast (
    .clk(clk), .rst(rst), .clear_n(f_clear_n), .load_n(1'b1), .ep(f_en), .et(f_en),
    .i_preset(4'd0),
`ifdef SYNC_CNT_UPDOWN_EN
    .up_dn(f_up_dn),
`endif
    .o_q(f_q), .o_tick(f_tick), .o_rco(f_rco));

  // Reference: one up step of a modulo-M digit.
  function automatic int ref_up(input int v);
    return (v >= M - 1) ? 0 : v + 1;
  endfunction

  function automatic bit exp_tick();
    return ep && et && (m_pre == P - 1);
  endfunction

  function automatic bit exp_rco();
    return et && (m_q == M - 1);
  endfunction

  // Advance one clock, updating the reference from the inputs seen before the edge.
  task automatic clk_main();
    int nq, np;
    nq = m_q;
    np = m_pre;
    if (!clear_n) begin
      nq = 0; np = 0;
    end else if (!load_n) begin
      nq = int'(preset); np = 0;
    end else if (ep && et) begin
      if (m_pre == P - 1) begin
        np = 0; nq = ref_up(m_q);
      end else begin
        np = m_pre + 1;
      end
    end
    @(posedge clk);
    #1;
    m_q   = nq;
    m_pre = np;
  endtask

  task automatic test_reset();
    ep = 1'b1; et = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (q !== 4'd0 || tick !== 1'b0 || rco !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: q=%0d tick=%b rco=%b expected q=0 tick=0 rco=0", q, tick, rco);
    end
    rst = 1'b0; m_q = 0; m_pre = 0;
    for (int i = 1; i <= 3; i++) begin
      clk_main();
      vectors++;
      if (q !== ((i == 3) ? 4'd1 : 4'd0)) begin
        errors++;
        $display("FAIL first_step: cycle %0d q=%0d expected %0d", i, q, (i == 3) ? 1 : 0);
      end
    end
    repeat (24) clk_main();
    vectors++;
    if (q !== 4'd9 || rco !== 1'b1) begin
      errors++;
      $display("FAIL reach_9: q=%0d rco=%b expected q=9 rco=1", q, rco);
    end
    repeat (3) clk_main();
    vectors++;
    if (q !== 4'd0) begin
      errors++;
      $display("FAIL wrap_9_0: q=%0d expected 0", q);
    end
    repeat (4) clk_main();
    #1 rst = 1'b1;
    #1;
    vectors++;
    if (q !== 4'd0 || tick !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: q=%0d tick=%b expected q=0 tick=0", q, tick);
    end
    #1 rst = 1'b0;
    m_q = 0; m_pre = 0;
    for (int i = 1; i <= 3; i++) begin
      clk_main();
      vectors++;
      if (q !== ((i == 3) ? 4'd1 : 4'd0)) begin
        errors++;
        $display("FAIL post_reset_step: cycle %0d q=%0d expected %0d", i, q, (i == 3) ? 1 : 0);
      end
    end
  endtask

  task automatic test_enable_rco();
    ep = 1'b0; et = 1'b0; load_n = 1'b0; preset = 4'd9;
    #1 clk_main();
    load_n = 1'b1; et = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (q !== 4'd9 || rco !== 1'b1 || tick !== 1'b0) begin
        errors++;
        $display("FAIL et_only_hold: q=%0d rco=%b tick=%b expected q=9 rco=1 tick=0", q, rco, tick);
      end
      clk_main();
    end
    et = 1'b0;
    #1;
    vectors++;
    if (rco !== 1'b0) begin
      errors++;
      $display("FAIL et_gates_rco: rco=%b expected 0", rco);
    end
    ep = 1'b1; et = 1'b1;
    #1 clk_main();
    ep = 1'b0;
    #1 clk_main();
    clk_main();
    ep = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (tick !== exp_tick() || q !== 4'(m_q)) begin
        errors++;
        $display("FAIL frozen_pre: i=%0d q=%0d tick=%b expected q=%0d tick=%b", i, q, tick, m_q, exp_tick());
      end
      clk_main();
    end
    vectors++;
    if (q !== 4'd0) begin
      errors++;
      $display("FAIL resume_step: q=%0d expected 0", q);
    end
  endtask

  task automatic test_load_clear();
    ep = 1'b0; et = 1'b1; load_n = 1'b0; preset = 4'd12;
    #1 clk_main();
    load_n = 1'b1;
    #1;
    vectors++;
    if (q !== 4'd12 || rco !== 1'b0) begin
      errors++;
      $display("FAIL load_12: q=%0d rco=%b expected q=12 rco=0", q, rco);
    end
    ep = 1'b1;
    #1 repeat (3) clk_main();
    vectors++;
    if (q !== 4'd0) begin
      errors++;
      $display("FAIL out_of_range_wrap: q=%0d expected 0", q);
    end
    repeat (3) clk_main();
    clear_n = 1'b0; load_n = 1'b0; preset = 4'd7;
    #1 clk_main();
    clear_n = 1'b1; load_n = 1'b1;
    #1;
    vectors++;
    if (q !== 4'd0) begin
      errors++;
      $display("FAIL clear_over_load: q=%0d expected 0", q);
    end
  endtask

  task automatic test_collision();
    ep = 1'b1; et = 1'b1;
    clear_n = 1'b0;
    #1 clk_main();
    clear_n = 1'b1;
    #1 clk_main();
    clk_main();
    load_n = 1'b0; preset = 4'd5;
    #1;
    vectors++;
    if (tick !== 1'b1) begin
      errors++;
      $display("FAIL collision_tick: tick=%b expected 1", tick);
    end
    clk_main();
    load_n = 1'b1;
    #1;
    vectors++;
    if (q !== 4'd5) begin
      errors++;
      $display("FAIL collision_load: q=%0d expected 5", q);
    end
    for (int i = 1; i <= 3; i++) begin
      clk_main();
      vectors++;
      if (q !== ((i == 3) ? 4'd6 : 4'd5)) begin
        errors++;
        $display("FAIL post_collision: cycle %0d q=%0d expected %0d", i, q, (i == 3) ? 6 : 5);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      ep      = ($urandom_range(0, 3) != 0);
      et      = ($urandom_range(0, 3) != 0);
      clear_n = ($urandom_range(0, 15) != 0);
      load_n  = ($urandom_range(0, 7) != 0);
      preset  = 4'($urandom_range(0, 15));
      #1;
      vectors++;
      if (tick !== exp_tick() || rco !== exp_rco()) begin
        errors++;
        $display("FAIL random_comb: i=%0d tick=%b rco=%b expected tick=%b rco=%b", i, tick, rco, exp_tick(), exp_rco());
      end
      clk_main();
      vectors++;
      if (q !== 4'(m_q)) begin
        errors++;
        $display("FAIL random_q: i=%0d q=%0d expected %0d", i, q, m_q);
      end
    end
    clear_n = 1'b1; load_n = 1'b1;
  endtask

  task automatic test_cascade();
    int n, val;
    c_clear_n = 1'b0; c_en = 1'b0;
    @(posedge clk); #1;
    c_clear_n = 1'b1; c_en = 1'b1;
    n = 0;
    for (int i = 0; i < 320; i++) begin
      #1;
      vectors++;
      if (hi_tick !== ((((n / 3) % 10) == 9) && ((n % 3) == 2))) begin
        errors++;
        $display("FAIL cascade_carry: n=%0d hi_tick=%b lo_q=%0d", n, hi_tick, lo_q);
      end
      @(posedge clk); #1;
      n++;
      val = int'(hi_q) * 10 + int'(lo_q);
      vectors++;
      if (val !== (n / 3) % 100 || hi_rco !== (((n / 3) % 100) == 99)) begin
        errors++;
        $display("FAIL cascade_value: n=%0d value=%0d hi_rco=%b expected %0d", n, val, hi_rco, (n / 3) % 100);
      end
    end
    c_en = 1'b0;
  endtask

  task automatic test_fast();
    int e;
    f_up_dn = 1'b1; f_en = 1'b0; f_clear_n = 1'b0;
    @(posedge clk); #1;
    f_clear_n = 1'b1; f_en = 1'b1;
`ifdef SYNC_CNT_UPDOWN_EN
    f_up_dn = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      e = (10 - (k % 10)) % 10;
      vectors++;
      if (f_q !== 4'(e) || f_tick !== 1'b1 || f_rco !== (e == 0)) begin
        errors++;
        $display("FAIL down_count: k=%0d q=%0d tick=%b rco=%b expected q=%0d", k, f_q, f_tick, f_rco, e);
      end
    end
    f_up_dn = 1'b1;
    #1;
    vectors++;
    if (f_rco !== 1'b0) begin
      errors++;
      $display("FAIL dir_terminal_swap: rco=%b expected 0", f_rco);
    end
`endif
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      e = k % 10;
      vectors++;
      if (f_q !== 4'(e) || f_tick !== 1'b1 || f_rco !== (e == 9)) begin
        errors++;
        $display("FAIL fast_up: k=%0d q=%0d tick=%b rco=%b expected q=%0d", k, f_q, f_tick, f_rco, e);
      end
    end
    f_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clear_n = 1'b1; load_n = 1'b1; ep = 1'b0; et = 1'b0; preset = 4'd0;
    c_clear_n = 1'b1; c_en = 1'b0; f_clear_n = 1'b1; f_en = 1'b0; f_up_dn = 1'b1;
    m_q = 0; m_pre = 0;
    test_reset();
    test_enable_rco();
    test_load_clear();
    test_collision();
    test_random();
    test_cascade();
    test_fast();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
